// File: rtl/lc3_mem_ctrl.sv
// rtl/lc3_mem_ctrl.sv - LC-3 single-word memory access controller with four-phase R handshake
// Optional R-edge timeout enabled by defining MEM_CTRL_TIMEOUT_EN.
module lc3_mem_ctrl #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int MEM_DEPTH      = 28800,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              REQ,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [DATA_W-1:0] RDATA,
    output logic              MEM_EN,
    output logic              RW,
    output logic [ADDR_W-1:0] MAR_OUT,
    output logic [DATA_W-1:0] MDR_OUT,
    input  logic              R,
    input  logic [DATA_W-1:0] MEM_OUT
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RELEASE} state_t;

    localparam logic [ADDR_W:0] DEPTH_L = MEM_DEPTH[ADDR_W:0];

    state_t            state, state_nx;
    logic              in_range;
    logic              mem_en_nx, rw_nx, done_nx, err_nx, busy_nx;
    logic [ADDR_W-1:0] mar_nx;
    logic [DATA_W-1:0] mdr_nx, rdata_nx;
    logic              tmo_hit, tmo_pend;

    assign in_range = ({1'b0, ADDR} < DEPTH_L);

`ifdef MEM_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Counter restarts on every state change; pending error survives ACCESS->RELEASE only.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tmo_cnt  <= '0;
            tmo_pend <= 1'b0;
        end else begin
            if (state_nx != state)
                tmo_cnt <= '0;
            else if (state != S_IDLE)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (state_nx == S_IDLE)
                tmo_pend <= 1'b0;
            else if (state == S_ACCESS && !R && tmo_hit)
                tmo_pend <= 1'b1;
        end
    end
`else
    // No timeout: the compare is never true for any legal parameter value.
    assign tmo_hit  = (TIMEOUT_CYCLES < 0);
    assign tmo_pend = 1'b0;
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= S_IDLE;
            MEM_EN  <= 1'b0;
            RW      <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
            MAR_OUT <= '0;
            MDR_OUT <= '0;
            RDATA   <= '0;
        end else begin
            state   <= state_nx;
            MEM_EN  <= mem_en_nx;
            RW      <= rw_nx;
            BUSY    <= busy_nx;
            DONE    <= done_nx;
            ERR     <= err_nx;
            MAR_OUT <= mar_nx;
            MDR_OUT <= mdr_nx;
            RDATA   <= rdata_nx;
        end
    end

    // A stale R left over from an aborted access blocks a new start until it clears.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (REQ && in_range && !R) state_nx = S_ACCESS;
            S_ACCESS:  if (R || tmo_hit) state_nx = S_RELEASE;
            S_RELEASE: if (!R || tmo_hit) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        mem_en_nx = MEM_EN;
        rw_nx     = RW;
        mar_nx    = MAR_OUT;
        mdr_nx    = MDR_OUT;
        rdata_nx  = RDATA;
        done_nx   = 1'b0;
        err_nx    = 1'b0;
        case (state)
            S_IDLE: begin
                if (REQ && !in_range) begin
                    done_nx = 1'b1;
                    err_nx  = 1'b1;
                end else if (REQ && !R) begin
                    mar_nx    = ADDR;
                    mdr_nx    = WDATA;
                    rw_nx     = WE;
                    mem_en_nx = 1'b1;
                end
            end
            S_ACCESS: begin
                if (R) begin
                    if (!RW)
                        rdata_nx = MEM_OUT;
                    mem_en_nx = 1'b0;
                end else if (tmo_hit) begin
                    mem_en_nx = 1'b0;
                end
            end
            S_RELEASE: begin
                if (!R) begin
                    done_nx = 1'b1;
                    err_nx  = tmo_pend;
                end else if (tmo_hit) begin
                    done_nx = 1'b1;
                    err_nx  = 1'b1;
                end
            end
            default: ;
        endcase
        busy_nx = (state_nx != S_IDLE);
    end

endmodule
